// File: rtl/legv8_pkg.sv
// Shared Execute-stage definitions: word width (overridable through `WORD),
// divider FSM state encoding and the most-negative word constant.
`ifndef WORD
`define WORD 64
`endif

package legv8_pkg;

  localparam int WORD_W = `WORD;

  localparam logic [WORD_W-1:0] WORD_MIN = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/execute_divider_if.sv
// Divider request/result bundle between Decode/Writeback (master) and the divider (slave).
interface execute_divider_if #(parameter int WIDTH = 64);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/execute_divider_div_step.sv
// One radix-2 restoring division step, purely combinational.
// The subtraction is one bit wider than the operands so that its borrow selects the restore.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // R stays below 2^(k) after k steps, so the shift never drops a set bit
  assign r_sh   = {r[WIDTH-2:0], q[WIDTH-1]};
  assign diff   = {1'b0, r_sh} - {1'b0, d};
  assign borrow = diff[WIDTH];

  assign r_next = borrow ? r_sh : diff[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/execute_divider.sv
// Multi-cycle restoring UDIV/SDIV: sign prep, WIDTH iterations, sign fix-up; done WIDTH+3 cycles after start.
// Optional EXECUTE_DIVIDER_FAST_PATH_EN skips iteration when the quotient is trivially zero.
module execute_divider
  import legv8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  execute_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_lat, d_lat;
  logic             sgn_lat;
  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [WIDTH-1:0] step_q, step_r;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, dz;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             dz_out;

  logic             a_neg, d_neg;
  logic [WIDTH-1:0] a_mag, d_mag;
  logic             skip;

  assign a_neg = sgn_lat & a_lat[WIDTH-1];
  assign d_neg = sgn_lat & d_lat[WIDTH-1];
  assign a_mag = a_neg ? -a_lat : a_lat;
  assign d_mag = d_neg ? -d_lat : d_lat;

`ifdef EXECUTE_DIVIDER_FAST_PATH_EN
  assign skip = (d_lat == '0) || (a_mag < d_mag);
`else
  assign skip = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .q      (q_r),
    .d      (d_r),
    .r_next (step_r),
    .q_next (step_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = skip ? FIX : ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = bus.start ? PREP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_lat       <= '0;
      d_lat       <= '0;
      sgn_lat     <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_out      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_lat   <= bus.dividend;
            d_lat   <= bus.divisor;
            sgn_lat <= bus.is_signed;
          end
        end
        PREP: begin
          q_r   <= skip ? '0 : a_mag;
          r_r   <= skip ? a_mag : '0;
          d_r   <= d_mag;
          neg_q <= a_neg ^ d_neg;
          neg_r <= a_neg;
          dz    <= (d_lat == '0);
          cnt   <= CNT_W'(WIDTH - 1);
        end
        ITER: begin
          q_r <= step_q;
          r_r <= step_r;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          // Divide-by-zero returns the untouched dividend regardless of signedness
          quotient_r  <= dz ? '0 : (neg_q ? -q_r : q_r);
          remainder_r <= dz ? a_lat : (neg_r ? -r_r : r_r);
          dz_out      <= dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == PREP) || (state == ITER) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_out;

endmodule

// File: doc/execute_divider.md
# execute_divider

Multi-cycle integer divider for the Execute stage, serving UDIV and SDIV. Decode supplies the register operands; this block returns quotient and remainder to the Writeback mux. While `busy` is high, the datapath holds Fetch's PC and suppresses the register write clock. The block is a radix-2 restoring divider with explicit sign pre- and post-processing.

## Interface
- `WIDTH`, default 64 (`` `WORD ``): operand and result width.
- `clk`  in  1  stage clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled on `clk` rising edge.
- `is_signed`  in  1  1 = SDIV (two's complement), 0 = UDIV; sampled with `start`.
- `dividend`  in  WIDTH  Rn operand; sampled with `start`.
- `divisor`  in  WIDTH  Rm operand; sampled with `start`.
- `quotient`  out  WIDTH  result to Writeback.
- `remainder`  out  WIDTH  remainder, for an MSUB-based modulo sequence.
- `busy`  out  1  division in progress; drives the pipeline hold.
- `done`  out  1  one-cycle pulse; results valid.
- `div_by_zero`  out  1  last operation had divisor == 0; held with the results.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE or DONE, with `start`=1:
  - Latch the operands and `is_signed`.
  - Go to PREP.
  - In any other state, `start` is ignored.
- PREP (1 cycle):
  - If signed, take the absolute value of each operand.
  - Record `neg_q` = sign(dividend) XOR sign(divisor), and `neg_r` = sign(dividend).
  - Clear the partial remainder and load the iteration counter with WIDTH-1.
- ITER (WIDTH cycles), one step per cycle:
  - R = {R[WIDTH-2:0], Q[WIDTH-1]}; Q <<= 1.
  - If R ≥ D, then R -= D and Q[0] = 1.
  - The subtraction is WIDTH+1 bits wide; its borrow selects the restore.
  - When the counter reaches 0, go to FIX.
- FIX (1 cycle):
  - Negate Q if `neg_q`, and negate R if `neg_r`.
  - Drive `quotient`/`remainder`.
- DONE (1 cycle): `done`=1, then return to IDLE (or to PREP on `start`).
- Divisor == 0:
  - `quotient`=0 and `remainder`=dividend (unmodified), matching ARM SDIV/UDIV semantics.
  - `div_by_zero`=1.
- Signed overflow, MIN / -1: `quotient`=MIN (0x8000…0) and `remainder`=0. This falls out naturally from the magnitude path and WIDTH-bit truncation; no special case is needed.
- `quotient`, `remainder` and `div_by_zero` hold their values from FIX until the next FIX.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `quotient`=0, `remainder`=0, and all internal registers = 0.
- Latency: when `start` is sampled at edge 0, `done` is high during cycle WIDTH+3 (67 for WIDTH=64).
- `busy`=1 in PREP, ITER and FIX; `busy`=0 in IDLE and DONE.
- Back-to-back: `start` asserted during the DONE cycle is accepted, so there are no idle bubbles between operations.
- Reset asserted mid-operation: the operation aborts immediately, `done` never pulses, and outputs return to 0.
- Operand inputs may change freely after the sampling edge.

## Configuration
- `EXECUTE_DIVIDER_FAST_PATH_EN` defined:
  - In PREP, if divisor == 0, or |dividend| < |divisor| as unsigned magnitudes, skip ITER.
  - Go directly to FIX with Q=0 and R=|dividend|; sign fix-up still applies.
  - `done` is then high in cycle 3 after `start`.
- Macro undefined: every operation takes the full WIDTH+3 latency; the divide-by-zero results are identical.

## Structure
- Shared package `legv8_pkg`: `` `WORD ``-derived `WORD_W` constant, `div_state_t` enum (IDLE/PREP/ITER/FIX/DONE), `WORD_MIN` constant.
- Sub-module `div_step`: combinational single restoring step. Inputs R, Q, D; outputs next R and next Q. It is instantiated once inside the FSM.

## Test plan
- Unsigned 100 / 7 → `quotient`=14, `remainder`=2, `div_by_zero`=0. `done` pulses exactly at cycle 67 and `busy` is high in cycles 1–66.
- Signed -100 / 7 → `quotient`=-14 (0xFFFF_FFFF_FFFF_FFF2), `remainder`=-2. Signed 100 / -7 → `quotient`=-14, `remainder`=2.
- Divisor 0, dividend 0x1234:
  - `quotient`=0, `remainder`=0x1234, `div_by_zero`=1.
  - `done` at cycle 67 with the macro off, cycle 3 with it on.
- Signed 0x8000_0000_0000_0000 / -1 → `quotient`=0x8000_0000_0000_0000, `remainder`=0. Unsigned 0xFFFF…F / 1 → `quotient`=0xFFFF…F, `remainder`=0.
- Reset pulled low at cycle 30 of an operation → `busy`=0 and all outputs 0 immediately. No `done` pulse follows; a new `start` after release completes correctly.
- `start` held during DONE with new operands 50 / 5:
  - The second operation begins without an IDLE cycle.
  - It yields `quotient`=10, `remainder`=0.
  - The first result stays stable until the second FIX.
